bsort_engine: RTL and testbench
===============================

# bsort_engine

Parametrised in-place bubble-sort engine: a register file of DEPTH entries of WIDTH bits, loaded word by word, sorted on command in ascending or descending order, and read back through an address port. It is the successor of the fixed 8×8-bit sorter and adds:

- generic width and depth;
- a runtime sort direction;
- a start/busy/done handshake;
- a swap counter;
- optional early termination.

It sits between the host load/readback logic and any consumer of sorted data.

## Interface
- WIDTH, 8, data word width (≥1)
- DEPTH, 8, number of entries (≥2)
- AW, $clog2(DEPTH), address width (derived, not overridden)
- CW, $clog2(DEPTH*(DEPTH-1)/2+1), swap-counter width (derived)

- clk_in  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low; clears all state and register contents
- load  input  1  write DIN to entry addr this cycle (IDLE only)
- addr  input  AW  load address
- DIN  input  WIDTH  load data
- start  input  1  begin sort (IDLE only, load=0)
- descend  input  1  0 = ascending, 1 = descending; sampled with start
- rd_addr  input  AW  readback address
- DOUT  output  WIDTH  combinational read of entry rd_addr
- busy  output  1  sort in progress
- done  output  1  one-cycle pulse at completion
- k  output  AW  current pass index i
- j  output  AW  current compare index
- swaps  output  CW  swaps performed by the last/current sort

## Operation
- States: IDLE, CMP, PASS_END, DONE.
- IDLE:
  - load=1 writes DIN to entry addr.
  - start=1 with load=0 latches descend, clears i, j and swaps, and moves to CMP.
  - load=1 together with start=1 performs the load only; start is ignored.
- CMP, one compare per cycle on entries j and j+1:
  - Swap condition: ascending when rf[j] > rf[j+1]; descending when rf[j] < rf[j+1].
  - Equal values never swap, so the sort is stable.
  - A swap writes both entries at the clock edge, increments swaps, and sets the pass_swapped flag.
  - If j == DEPTH-2-i, go to PASS_END; otherwise j <= j+1.
- PASS_END:
  - i <= i+1, j <= 0, pass_swapped cleared.
  - Go to DONE if the new i == DEPTH-1, or if BSORT_EARLY_EXIT_EN is defined and the pass made no swap; otherwise go to CMP.
- DONE: done=1 for one cycle, then IDLE.
- load and start are ignored outside IDLE. descend is ignored after the start cycle.
- Comparisons are unsigned, on full WIDTH.
- When DEPTH is not a power of two, out-of-range addresses behave as follows:
  - writes are ignored;
  - DOUT returns 0.
- DOUT is valid in every state. During a sort it shows intermediate contents.
- swaps holds its value after DONE until the next accepted start.

## Timing
- Reset values: state IDLE; busy, done, k, j and swaps all 0; all entries 0.
- A load write is visible on DOUT the cycle after the edge.
- busy is high exactly in the CMP and PASS_END states.
- Full sort: D(D-1)/2 CMP cycles plus D-1 PASS_END cycles.
  - DEPTH=8: 35 busy cycles; done asserts in cycle 36 after the start edge.
- Early exit on an already-sorted input: DEPTH-1 CMP cycles + 1 PASS_END, then DONE.
  - DEPTH=8: 8 busy cycles.
- A reset assertion mid-sort aborts immediately:
  - no done pulse;
  - contents cleared;
  - after release, the engine accepts load in the first cycle.
- start may be asserted in the cycle after done (back-to-back sorts). DONE itself ignores start.

## Configuration
- BSORT_EARLY_EXIT_EN
  - Defined: the sort terminates at the first PASS_END whose pass made no swap.
  - Undefined: all DEPTH-1 passes always run, giving a fixed latency; pass_swapped logic is removed.
  - Sorted results and swaps are identical either way.

## Structure
- Package bsort_pkg holds:
  - the state enum (IDLE, CMP, PASS_END, DONE);
  - helper functions for the AW and CW derivations;
  - default WIDTH and DEPTH constants.
- Sub-module bsort_cmp_swap (combinational):
  - inputs: a, b, descend;
  - outputs: lo_out, hi_out, swap.
  - It replaces the old fixed-width swap unit.
- The top level holds the FSM, counters i and j, the register file, and the swap counter.

## Test plan
- Load 8,7,6,5,4,3,2,1 (DEPTH=8, WIDTH=8), start with descend=0 -> readback 1..8; swaps=28; done in cycle 36; busy high 35 cycles.
- Same data, descend=1 -> readback 8..1; swaps=0. With BSORT_EARLY_EXIT_EN, done in cycle 9; without it, done in cycle 36.
- Load 3,1,3,0,255,1,0,2, ascending -> readback 0,0,1,1,2,3,3,255. Equal values are never swapped, checked by a scoreboard on swap events.
- Assert reset (low) at cycle 10 of a sort -> busy=0 and swaps=0 at once; DOUT=0 at every address; no done pulse.
- Issue load and start pulses while busy -> no change to contents or FSM sequence versus an undisturbed run.
- WIDTH=12, DEPTH=5: load 4095,0,2048,1,2048 ascending -> readback 0,1,2048,2048,4095; addresses 5..7 read 0 and ignore writes.

Source files
------------

// File: rtl/bsort_pkg.sv
// Shared types and constants for the bsort_engine bubble-sort block.
package bsort_pkg;

    localparam int unsigned BSORT_WIDTH_DEF = 8;
    localparam int unsigned BSORT_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        PASS_END,
        DONE
    } bsort_state_e;

    function automatic int unsigned calc_aw(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Worst case is one swap per compare: depth*(depth-1)/2.
    function automatic int unsigned calc_cw(input int unsigned depth);
        return $clog2(depth * (depth - 1) / 2 + 1);
    endfunction

endpackage

// File: rtl/bsort_if.sv
// Host-side load/start/readback bundle of bsort_engine; master = host, slave = engine.
interface bsort_if
    import bsort_pkg::*;
#(
    parameter int unsigned WIDTH = BSORT_WIDTH_DEF,
    parameter int unsigned DEPTH = BSORT_DEPTH_DEF
) ();
    localparam int unsigned AW = calc_aw(DEPTH);
    localparam int unsigned CW = calc_cw(DEPTH);

    logic             load;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] DIN;
    logic             start;
    logic             descend;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] DOUT;
    logic             busy;
    logic             done;
    logic [AW-1:0]    k;
    logic [AW-1:0]    j;
    logic [CW-1:0]    swaps;

    modport master (
        output load, addr, DIN, start, descend, rd_addr,
        input  DOUT, busy, done, k, j, swaps
    );

    modport slave (
        input  load, addr, DIN, start, descend, rd_addr,
        output DOUT, busy, done, k, j, swaps
    );

endinterface

// File: rtl/bsort_cmp_swap.sv
// Compare/exchange cell: lo_out goes to the lower index, hi_out to the upper one.
module bsort_cmp_swap
    import bsort_pkg::*;
#(
    parameter int unsigned WIDTH = BSORT_WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             descend,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out,
    output logic             swap
);

    // Strict compares keep equal keys in place, so the sort is stable.
    assign swap   = descend ? (a < b) : (a > b);
    assign lo_out = swap ? b : a;
    assign hi_out = swap ? a : b;

endmodule

// File: rtl/bsort_engine.sv
// In-place bubble-sort engine over a DEPTH x WIDTH register file.
// Optional BSORT_EARLY_EXIT_EN: stop at the first pass that made no swap.
module bsort_engine
    import bsort_pkg::*;
#(
    parameter int unsigned WIDTH = BSORT_WIDTH_DEF,
    parameter int unsigned DEPTH = BSORT_DEPTH_DEF
) (
    input logic    clk_in,
    input logic    reset,
    bsort_if.slave bus
);
    localparam int unsigned AW = calc_aw(DEPTH);
    localparam int unsigned CW = calc_cw(DEPTH);

    logic [WIDTH-1:0] r_rf [DEPTH];
    bsort_state_e     r_state, w_state_next;
    logic [AW-1:0]    r_i, w_i_next, w_i_inc;
    logic [AW-1:0]    r_j, w_j_next, w_j_plus1, w_j_last;
    logic [CW-1:0]    r_swaps, w_swaps_next;
    logic             r_descend, w_descend_next;
    logic             w_load_en, w_swap_en, w_wr_in_range, w_early_exit;
    logic [WIDTH-1:0] w_lo, w_hi;
    logic             w_swap;

    assign w_i_inc       = r_i + AW'(1);
    assign w_j_plus1     = r_j + AW'(1);
    assign w_j_last      = AW'(DEPTH - 2) - r_i;
    assign w_wr_in_range = (32'(bus.addr) < DEPTH);

    bsort_cmp_swap #(
        .WIDTH (WIDTH)
    ) u_cmp_swap (
        .a       (r_rf[r_j]),
        .b       (r_rf[w_j_plus1]),
        .descend (r_descend),
        .lo_out  (w_lo),
        .hi_out  (w_hi),
        .swap    (w_swap)
    );

`ifdef BSORT_EARLY_EXIT_EN
    logic r_pass_swapped;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_pass_swapped <= 1'b0;
        end else if (r_state == PASS_END) begin
            r_pass_swapped <= 1'b0;
        end else if (w_swap_en) begin
            r_pass_swapped <= 1'b1;
        end
    end

    assign w_early_exit = !r_pass_swapped;
`else
    assign w_early_exit = 1'b0;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_i_next       = r_i;
        w_j_next       = r_j;
        w_swaps_next   = r_swaps;
        w_descend_next = r_descend;
        w_load_en      = 1'b0;
        w_swap_en      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.load) begin
                    w_load_en = w_wr_in_range;
                end else if (bus.start) begin
                    w_state_next   = CMP;
                    w_i_next       = '0;
                    w_j_next       = '0;
                    w_swaps_next   = '0;
                    w_descend_next = bus.descend;
                end
            end
            CMP: begin
                w_swap_en = w_swap;
                if (w_swap) begin
                    w_swaps_next = r_swaps + CW'(1);
                end
                if (r_j == w_j_last) begin
                    w_state_next = PASS_END;
                end else begin
                    w_j_next = w_j_plus1;
                end
            end
            PASS_END: begin
                w_i_next = w_i_inc;
                w_j_next = '0;
                if ((w_i_inc == AW'(DEPTH - 1)) || w_early_exit) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = CMP;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_i       <= '0;
            r_j       <= '0;
            r_swaps   <= '0;
            r_descend <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_i       <= w_i_next;
            r_j       <= w_j_next;
            r_swaps   <= w_swaps_next;
            r_descend <= w_descend_next;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < DEPTH; n++) begin
                r_rf[n] <= '0;
            end
        end else if (w_load_en) begin
            r_rf[bus.addr] <= bus.DIN;
        end else if (w_swap_en) begin
            r_rf[r_j]       <= w_lo;
            r_rf[w_j_plus1] <= w_hi;
        end
    end

    assign bus.DOUT  = (32'(bus.rd_addr) < DEPTH) ? r_rf[bus.rd_addr] : '0;
    assign bus.busy  = (r_state == CMP) || (r_state == PASS_END);
    assign bus.done  = (r_state == DONE);
    assign bus.k     = r_i;
    assign bus.j     = r_j;
    assign bus.swaps = r_swaps;

endmodule

// File: tb/tb_bsort_engine.sv
// Randomized self-checking bench for bsort_engine (8x8 and 5x12 instances).
module tb_bsort_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    bsort_if #(.WIDTH(8), .DEPTH(8)) bus8 ();
    bsort_if #(.WIDTH(12), .DEPTH(5)) bus5 ();

    bsort_engine #(.WIDTH(8), .DEPTH(8)) dut8 (
        .clk_in (clk),
        .reset  (rst_n),
        .bus    (bus8)
    );

    bsort_engine #(.WIDTH(12), .DEPTH(5)) dut5 (
        .clk_in (clk),
        .reset  (rst_n),
        .bus    (bus5)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // Element a (earlier) and b (later) are out of order for this direction.
    function automatic bit m_out_of_order(input int a, input int b, input bit desc);
        return desc ? (a < b) : (a > b);
    endfunction

    function automatic int m_swaps(input int q[$], input bit desc);
        int c = 0;
        for (int x = 0; x < q.size(); x++)
            for (int y = x + 1; y < q.size(); y++)
                if (m_out_of_order(q[x], q[y], desc)) c++;
        return c;
    endfunction

    // Passes that move anything = max count of out-of-order elements ahead of any element.
    function automatic int m_busy(input int q[$], input bit desc);
        int d = q.size();
        int maxc = 0;
        int passes;
        int cyc = 0;
        for (int y = 0; y < d; y++) begin
            int c = 0;
            for (int x = 0; x < y; x++)
                if (m_out_of_order(q[x], q[y], desc)) c++;
            if (c > maxc) maxc = c;
        end
        passes = d - 1;
`ifdef BSORT_EARLY_EXIT_EN
        if (maxc + 1 < passes) passes = maxc + 1;
`endif
        for (int p = 0; p < passes; p++) cyc += (d - 1 - p) + 1;
        return cyc;
    endfunction

    task automatic run8(input int vals[$], input bit desc, input bit disturb, input string tag);
        int exp_r[$];
        int cyc = 0;
        int busy_cnt = 0;
        bit got_done = 0;
        exp_r = vals;
        if (desc) exp_r.rsort();
        else exp_r.sort();
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            bus8.load = 1'b1;
            bus8.addr = 3'(n);
            bus8.DIN  = 8'(vals[n]);
        end
        @(negedge clk);
        bus8.load    = 1'b0;
        bus8.start   = 1'b1;
        bus8.descend = desc;
        @(posedge clk);
        while (cyc < 200 && !got_done) begin
            @(negedge clk);
            cyc++;
            if (bus8.done) got_done = 1;
            else if (bus8.busy) busy_cnt++;
            bus8.start = 1'b0;
            bus8.load  = 1'b0;
            if (disturb && bus8.busy) begin
                bus8.load    = 1'($urandom_range(0, 1));
                bus8.start   = 1'($urandom_range(0, 1));
                bus8.descend = 1'($urandom_range(0, 1));
                bus8.addr    = 3'($urandom);
                bus8.DIN     = 8'($urandom);
            end
        end
        check($sformatf("%s_done_cycle", tag), got_done ? cyc : -1, m_busy(vals, desc) + 1);
        check($sformatf("%s_busy_cycles", tag), busy_cnt, m_busy(vals, desc));
        check($sformatf("%s_swaps", tag), int'(bus8.swaps), m_swaps(vals, desc));
        @(negedge clk);
        check($sformatf("%s_done_pulse", tag), int'(bus8.done), 0);
        for (int n = 0; n < 8; n++) begin
            bus8.rd_addr = 3'(n);
            #1;
            check($sformatf("%s_rd%0d", tag, n), int'(bus8.DOUT), exp_r[n]);
        end
    endtask

    initial begin
        int vals[$];
        int exp5[$];
        int cyc;
        int busy_cnt;
        int done_cnt;
        bit got_done;

        {bus8.load, bus8.addr, bus8.DIN, bus8.start, bus8.descend, bus8.rd_addr} = '0;
        {bus5.load, bus5.addr, bus5.DIN, bus5.start, bus5.descend, bus5.rd_addr} = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_busy", int'(bus8.busy), 0);
        check("rst_done", int'(bus8.done), 0);
        check("rst_k", int'(bus8.k), 0);
        check("rst_j", int'(bus8.j), 0);
        check("rst_swaps", int'(bus8.swaps), 0);
        for (int n = 0; n < 8; n++) begin
            bus8.rd_addr = 3'(n);
            #1;
            check($sformatf("rst_rd%0d", n), int'(bus8.DOUT), 0);
        end

        vals = '{8, 7, 6, 5, 4, 3, 2, 1};
        run8(vals, 1'b0, 1'b0, "rev_asc");
        run8(vals, 1'b1, 1'b0, "rev_desc");
        vals = '{3, 1, 3, 0, 255, 1, 0, 2};
        run8(vals, 1'b0, 1'b0, "dups_asc");
        run8(vals, 1'b0, 1'b1, "dups_disturb");

        for (int t = 0; t < 8; t++) begin
            vals = {};
            for (int n = 0; n < 8; n++)
                vals.push_back((t % 2 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255));
            run8(vals, 1'($urandom_range(0, 1)), 1'(t >= 4), $sformatf("rnd%0d", t));
        end

        // 5-entry, 12-bit instance: out-of-range addresses must not store or alias.
        vals = '{4095, 0, 2048, 1, 2048};
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            bus5.load = 1'b1;
            bus5.addr = 3'(n);
            bus5.DIN  = (n < 5) ? 12'(vals[n]) : 12'hABC;
        end
        @(negedge clk);
        bus5.load  = 1'b0;
        bus5.start = 1'b1;
        @(posedge clk);
        cyc = 0;
        busy_cnt = 0;
        got_done = 0;
        while (cyc < 200 && !got_done) begin
            @(negedge clk);
            cyc++;
            if (bus5.done) got_done = 1;
            else if (bus5.busy) busy_cnt++;
            bus5.start = 1'b0;
        end
        check("d5_done_cycle", got_done ? cyc : -1, m_busy(vals, 1'b0) + 1);
        check("d5_swaps", int'(bus5.swaps), 5);
        exp5 = '{0, 1, 2048, 2048, 4095, 0, 0, 0};
        for (int n = 0; n < 8; n++) begin
            bus5.rd_addr = 3'(n);
            #1;
            check($sformatf("d5_rd%0d", n), int'(bus5.DOUT), exp5[n]);
        end

        // Reset in the middle of a sort.
        vals = '{8, 7, 6, 5, 4, 3, 2, 1};
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            bus8.load = 1'b1;
            bus8.addr = 3'(n);
            bus8.DIN  = 8'(vals[n]);
        end
        @(negedge clk);
        bus8.load    = 1'b0;
        bus8.start   = 1'b1;
        bus8.descend = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy_before", int'(bus8.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_busy", int'(bus8.busy), 0);
        check("mid_swaps", int'(bus8.swaps), 0);
        for (int n = 0; n < 8; n++) begin
            bus8.rd_addr = 3'(n);
            #1;
            check($sformatf("mid_rd%0d", n), int'(bus8.DOUT), 0);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        bus8.load = 1'b1;
        bus8.addr = 3'd2;
        bus8.DIN  = 8'h5A;
        done_cnt  = 0;
        @(negedge clk);
        bus8.load    = 1'b0;
        bus8.rd_addr = 3'd2;
        #1;
        check("post_rst_load", int'(bus8.DOUT), 'h5A);
        repeat (40) begin
            @(negedge clk);
            if (bus8.done) done_cnt++;
        end
        check("post_rst_no_done", done_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
